// File: rtl/exec_stage.sv
// exec_stage: EX stage computing ALU/mul/div results, memory address and branch target,
// registered for MEM; a 32-step restoring divider holds the controller in EX via ex_busy.
module exec_stage #(
    parameter logic [2:0] EX_STATE   = 3'd2,
    parameter bit         DIV_ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  state,
    input  logic [4:0]  alu_op,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    input  logic        use_imm,
    input  logic [2:0]  br_op,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        reg_write_in,
    input  logic [4:0]  write_reg_in,
    output logic        ex_busy,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        branch,
    output logic [31:0] branch_addr,
    output logic        reg_write,
    output logic [4:0]  write_reg,
    output logic [31:0] reg_write_data
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
    div_state_t fsm, fsm_nx;
    logic        in_ex, div_op, signed_div, is_rem, a_neg, b_neg, cond, ge, capture;
    logic [31:0] opb, abs_a, abs_b, alu_res, div_res, q_fix, r_fix, sum_ai, mulh;
    logic [31:0] rem_q, quo_q, dsr_q, rem_nx;
    logic [32:0] rem_sh, diff;
    logic [4:0]  cnt;
    logic [63:0] mul_uu;

    assign in_ex      = state == EX_STATE;
    assign div_op     = alu_op >= 5'd13 && alu_op <= 5'd16;
    assign signed_div = alu_op == 5'd13 || alu_op == 5'd15;
    assign is_rem     = alu_op == 5'd15 || alu_op == 5'd16;
    assign opb        = use_imm ? imm : rs2_data;
    assign sum_ai     = rs1_data + imm;
    assign a_neg      = signed_div & rs1_data[31];
    assign b_neg      = signed_div & opb[31];
    assign abs_a      = a_neg ? -rs1_data : rs1_data;
    assign abs_b      = b_neg ? -opb : opb;
    assign ex_busy    = DIV_ENABLE && in_ex && div_op && fsm != DONE;
    assign capture    = in_ex && !ex_busy;

    // one unsigned multiplier; the signed high word is the unsigned one minus sign corrections
    assign mul_uu = {32'd0, rs1_data} * {32'd0, opb};
    assign mulh   = mul_uu[63:32] - (rs1_data[31] ? opb : 32'd0) - (opb[31] ? rs1_data : 32'd0);

    assign rem_sh = {rem_q, quo_q[31]};
    assign diff   = rem_sh - {1'b0, dsr_q};
    assign ge     = !diff[32];
    assign rem_nx = ge ? diff[31:0] : rem_sh[31:0];

    assign q_fix   = opb == '0 ? '1 : (a_neg ^ b_neg) ? -quo_q : quo_q;
    assign r_fix   = opb == '0 ? rs1_data : a_neg ? -rem_q : rem_q;
    assign div_res = DIV_ENABLE ? (is_rem ? r_fix : q_fix) : '0;

    assign cond = br_op == 3'd0 ? rs1_data == rs2_data :
                  br_op == 3'd1 ? rs1_data != rs2_data :
                  br_op == 3'd4 ? $signed(rs1_data) <  $signed(rs2_data) :
                  br_op == 3'd5 ? $signed(rs1_data) >= $signed(rs2_data) :
                  br_op == 3'd6 ? rs1_data <  rs2_data :
                  br_op == 3'd7 ? rs1_data >= rs2_data : 1'b0;

    always_comb begin
        alu_res = '0;
        case (alu_op)
            5'd0:  alu_res = rs1_data + opb;
            5'd1:  alu_res = rs1_data - opb;
            5'd2:  alu_res = rs1_data & opb;
            5'd3:  alu_res = rs1_data | opb;
            5'd4:  alu_res = rs1_data ^ opb;
            5'd5:  alu_res = rs1_data << opb[4:0];
            5'd6:  alu_res = rs1_data >> opb[4:0];
            5'd7:  alu_res = $unsigned($signed(rs1_data) >>> opb[4:0]);
            5'd8:  alu_res = {31'd0, $signed(rs1_data) < $signed(opb)};
            5'd9:  alu_res = {31'd0, rs1_data < opb};
            5'd10: alu_res = mul_uu[31:0];
            5'd11: alu_res = mulh;
            5'd12: alu_res = mul_uu[63:32];
            5'd13, 5'd14, 5'd15, 5'd16: alu_res = div_res;
            default: alu_res = '0;
        endcase
    end

    // leaving EX or dropping the divide op at any point aborts the divider
    always_comb begin
        fsm_nx = IDLE;
        if (DIV_ENABLE && in_ex && div_op)
            fsm_nx = fsm == IDLE ? RUN : fsm == RUN ? (cnt == 5'd31 ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm            <= IDLE;
            cnt            <= '0;
            rem_q          <= '0;
            quo_q          <= '0;
            dsr_q          <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            branch         <= 1'b0;
            branch_addr    <= '0;
            reg_write      <= 1'b0;
            write_reg      <= '0;
            reg_write_data <= '0;
        end else begin
            fsm <= fsm_nx;
            if (fsm == IDLE) begin
                rem_q <= '0;
                quo_q <= abs_a;
                dsr_q <= abs_b;
                cnt   <= '0;
            end else if (fsm == RUN) begin
                rem_q <= rem_nx;
                quo_q <= {quo_q[30:0], ge};
                cnt   <= cnt + 5'd1;
            end
            if (capture) begin
                mem_read       <= mem_read_in;
                mem_write      <= mem_write_in;
                mem_addr       <= sum_ai;
                mem_write_data <= rs2_data;
                branch         <= is_jal | is_jalr | (is_branch & cond);
                branch_addr    <= is_jalr ? {sum_ai[31:1], 1'b0} : pc + imm;
                reg_write      <= reg_write_in;
                write_reg      <= write_reg_in;
                reg_write_data <= (is_jal | is_jalr) ? pc + 32'd4 : alu_res;
            end
        end
    end
endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: directed vectors checked against a behavioural model of the EX stage.
module tb_exec_stage;
    logic        clk = 1'b0, rst;
    logic [2:0]  state, br_op;
    logic [4:0]  alu_op, write_reg_in, write_reg;
    logic [31:0] rs1_data, rs2_data, imm, pc;
    logic        use_imm, is_branch, is_jal, is_jalr, mem_read_in, mem_write_in, reg_write_in;
    logic        ex_busy, mem_read, mem_write, branch, reg_write;
    logic [31:0] mem_addr, mem_write_data, branch_addr, reg_write_data;

    exec_stage dut (
        .clk(clk), .rst(rst), .state(state), .alu_op(alu_op), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .imm(imm), .pc(pc), .use_imm(use_imm), .br_op(br_op),
        .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .reg_write_in(reg_write_in), .write_reg_in(write_reg_in),
        .ex_busy(ex_busy), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .branch(branch), .branch_addr(branch_addr),
        .reg_write(reg_write), .write_reg(write_reg), .reg_write_data(reg_write_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] op; logic [31:0] a, b, imm, pc; logic ui; logic [2:0] br;
        logic isb, jal, jalr, mr, mw, rw; logic [4:0] rd;
    } op_t;
    typedef struct {
        logic mr, mw, br, rw; logic [31:0] addr, wdata, baddr, rdata; logic [4:0] rd;
    } exp_t;

    int   errs = 0, checks = 0;
    logic chk_en = 1'b0;
    exp_t want;
    op_t  o;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] e);
        checks++;
        if (act !== e) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, e);
        end
    endtask

    function automatic logic [31:0] alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint     sa = longint'($signed(a));
        longint     sb = longint'($signed(b));
        logic [63:0] pu = {32'd0, a} * {32'd0, b};
        logic       ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a & b;
            5'd3:  return a | b;
            5'd4:  return a ^ b;
            5'd5:  return a << b[4:0];
            5'd6:  return a >> b[4:0];
            5'd7:  return 32'((sa >>> b[4:0]));
            5'd8:  return sa < sb ? 32'd1 : 32'd0;
            5'd9:  return a < b ? 32'd1 : 32'd0;
            5'd10: return pu[31:0];
            5'd11: return 32'((sa * sb) >>> 32);
            5'd12: return pu[63:32];
            5'd13: return b == 0 ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            5'd14: return b == 0 ? 32'hFFFF_FFFF : a / b;
            5'd15: return b == 0 ? a : ovf ? 32'd0 : 32'(sa % sb);
            5'd16: return b == 0 ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic exp_t model(input op_t x);
        exp_t m;
        logic t;
        case (x.br)
            3'd0: t = x.a == x.b;
            3'd1: t = x.a != x.b;
            3'd4: t = $signed(x.a) < $signed(x.b);
            3'd5: t = $signed(x.a) >= $signed(x.b);
            3'd6: t = x.a < x.b;
            3'd7: t = x.a >= x.b;
            default: t = 1'b0;
        endcase
        m.mr    = x.mr;
        m.mw    = x.mw;
        m.rw    = x.rw;
        m.rd    = x.rd;
        m.addr  = x.a + x.imm;
        m.wdata = x.b;
        m.br    = x.jal | x.jalr | (x.isb & t);
        m.baddr = x.jalr ? ((x.a + x.imm) & ~32'd1) : x.pc + x.imm;
        m.rdata = (x.jal | x.jalr) ? x.pc + 32'd4 : alu_model(x.op, x.a, x.ui ? x.imm : x.b);
        return m;
    endfunction

    function automatic op_t mk(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] im, input logic ui);
        op_t x = '{default: 0};
        x.op  = op;
        x.a   = a;
        x.b   = b;
        x.imm = im;
        x.ui  = ui;
        x.pc  = 32'h0000_1000;
        x.rw  = 1'b1;
        x.rd  = op + 5'd3;
        return x;
    endfunction

    task automatic drive(input op_t x);
        alu_op = x.op; rs1_data = x.a; rs2_data = x.b; imm = x.imm; pc = x.pc; use_imm = x.ui;
        br_op = x.br; is_branch = x.isb; is_jal = x.jal; is_jalr = x.jalr;
        mem_read_in = x.mr; mem_write_in = x.mw; reg_write_in = x.rw; write_reg_in = x.rd;
    endtask

    // enters at a negedge; holds EX until ex_busy drops, then spends 2 cycles in MEM
    task automatic run(input op_t x);
        int   n = 0, busy = 0;
        logic b;
        drive(x);
        state = 3'd2;
        do begin
            #1;
            b = ex_busy;
            busy += int'(b);
            chk_en = b;
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (b && n < 100);
        chk($sformatf("busy_cycles op%0d", x.op), busy, (x.op >= 13 && x.op <= 16) ? 33 : 0);
        want   = model(x);
        state  = 3'd3;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            chk("mem_read", 32'(mem_read), 32'(want.mr));
            chk("mem_write", 32'(mem_write), 32'(want.mw));
            chk("mem_addr", mem_addr, want.addr);
            chk("mem_write_data", mem_write_data, want.wdata);
            chk("branch", 32'(branch), 32'(want.br));
            chk("branch_addr", branch_addr, want.baddr);
            chk("reg_write", 32'(reg_write), 32'(want.rw));
            chk("write_reg", 32'(write_reg), 32'(want.rd));
            chk("reg_write_data", reg_write_data, want.rdata);
            if (state == 3'd3) chk("ex_busy_mem", 32'(ex_busy), 32'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        state = 3'd0;
        drive(mk(0, 0, 0, 0, 0));
        want = '{default: 0};
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        o = mk(0, 5, 0, -3, 1);                        run(o); chk("add_lit", reg_write_data, 32'd2);
        o = mk(0, 32'h100, 32'hDEAD, 8, 1); o.mw = 1; o.rw = 0; run(o);
        chk("st_addr", mem_addr, 32'h108); chk("st_data", mem_write_data, 32'hDEAD);
        chk("st_we", 32'(mem_write), 32'd1);
        o = mk(0, 32'h200, 0, -4, 1); o.mr = 1;       run(o);
        o = mk(0, -1, 1, 32'h20, 0); o.isb = 1; o.br = 4; o.pc = 32'h40; o.rw = 0; run(o);
        chk("blt_taken", 32'(branch), 32'd1); chk("blt_target", branch_addr, 32'h60);
        o = mk(0, 3, 4, 8, 0); o.isb = 1; o.br = 0; o.rw = 0;           run(o);
        o = mk(0, 3, 3, 8, 0); o.isb = 1; o.br = 1; o.rw = 0;           run(o);
        o = mk(0, -1, 1, 8, 0); o.isb = 1; o.br = 7; o.rw = 0;          run(o);
        o = mk(0, 2, -5, 8, 0); o.isb = 1; o.br = 5; o.rw = 0;          run(o);
        o = mk(0, 0, 0, -16, 0); o.jal = 1; o.pc = 32'h80;              run(o);
        chk("jal_target", branch_addr, 32'h70); chk("jal_link", reg_write_data, 32'h84);
        o = mk(0, 32'h101, 0, 0, 0); o.jalr = 1; o.pc = 32'h90;         run(o);
        chk("jalr_target", branch_addr, 32'h100); chk("jalr_link", reg_write_data, 32'h94);

        o = mk(1, 10, 3, 0, 0);                          run(o);
        o = mk(2, 32'hF0F0, 32'hFF00, 0, 0);             run(o);
        o = mk(3, 32'hF0F0, 32'h0F0F, 0, 0);             run(o);
        o = mk(4, 32'hFFFF, 32'h0F0F, 0, 0);             run(o);
        o = mk(5, 1, 33, 0, 0);                          run(o); chk("sll_lit", reg_write_data, 32'd2);
        o = mk(6, 32'h8000_0000, 4, 0, 0);               run(o);
        o = mk(7, 32'h8000_0000, 4, 0, 0);               run(o); chk("sra_lit", reg_write_data, 32'hF800_0000);
        o = mk(8, -1, 1, 0, 0);                          run(o);
        o = mk(9, -1, 1, 0, 0);                          run(o);
        o = mk(10, 7, -3, 0, 0);                         run(o); chk("mul_lit", reg_write_data, 32'hFFFF_FFEB);
        o = mk(11, -2, 3, 0, 0);                         run(o); chk("mulh_lit", reg_write_data, 32'hFFFF_FFFF);
        o = mk(11, 32'h8000_0000, 32'h8000_0000, 0, 0);  run(o);
        o = mk(12, -1, -1, 0, 0);                        run(o); chk("mulhu_lit", reg_write_data, 32'hFFFF_FFFE);

        o = mk(13, -7, 2, 0, 0);                         run(o); chk("div_lit", reg_write_data, 32'hFFFF_FFFD);
        o = mk(15, -7, 2, 0, 0);                         run(o); chk("rem_lit", reg_write_data, 32'hFFFF_FFFF);
        o = mk(14, 7, 0, 0, 0);                          run(o); chk("divu0_lit", reg_write_data, 32'hFFFF_FFFF);
        o = mk(15, 5, 0, 0, 0);                          run(o); chk("rem0_lit", reg_write_data, 32'd5);
        o = mk(13, -5, 0, 0, 0);                         run(o);
        o = mk(13, 32'h8000_0000, -1, 0, 0);             run(o); chk("div_ovf_lit", reg_write_data, 32'h8000_0000);
        o = mk(15, 32'h8000_0000, -1, 0, 0);             run(o);
        o = mk(13, 7, -2, 0, 0);                         run(o);
        o = mk(15, 7, -2, 0, 0);                         run(o); chk("rem_neg_div_lit", reg_write_data, 32'd1);
        o = mk(14, 100, 7, 0, 0);                        run(o);
        o = mk(16, 32'hFFFF_FFF0, 7, 0, 0);              run(o);
        o = mk(13, 1000, 9, 0, 1);                       run(o);

        // abort: leaving EX mid-divide must restart the divider and leave outputs untouched
        o = mk(14, 100, 7, 0, 0);
        drive(o);
        state = 3'd2;
        chk_en = 1'b1;
        repeat (5) @(negedge clk);
        state = 3'd0;
        repeat (2) @(negedge clk);
        run(o);

        // reset mid-divide clears outputs and the divider
        o = mk(13, -7, 2, 0, 0);
        drive(o);
        state = 3'd2;
        repeat (10) @(negedge clk);
        chk_en = 1'b0;
        rst = 1'b1;
        state = 3'd0;
        @(negedge clk);
        rst = 1'b0;
        want = '{default: 0};
        chk_en = 1'b1;
        #1 chk("rst_busy", 32'(ex_busy), 32'd0);
        chk("rst_rdata", reg_write_data, 32'd0);
        @(negedge clk);
        run(o);
        chk("div_after_rst", reg_write_data, 32'hFFFF_FFFD);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
